// File: rtl/tetris_board_renderer.sv
// Two-stage pixel pipeline: draws the 10x20 playfield and the 4x4 next-piece window
// from incremental cell counters and emits 1-bit R/G/B with syncs aligned to the pixels.
module tetris_board_renderer #(
   parameter int BOARD_X0 = 214,
   parameter int BOARD_Y0 = 29,
   parameter int PITCH    = 21,
   parameter int COLS     = 10,
   parameter int ROWS     = 20,
   parameter int NEXT_X0  = 445,
   parameter int NEXT_Y0  = 29
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [9:0]  CounterX,
   input  logic [9:0]  CounterY,
   input  logic        inDisplayArea,
   input  logic        HS_IN,
   input  logic        VS_IN,
   output logic [7:0]  CELL_ADDR,
   input  logic [2:0]  CELL_DATA,
   input  logic [15:0] NEXT_MASK,
   input  logic [2:0]  NEXT_COLOR,
   output logic        R,
   output logic        G,
   output logic        B,
   output logic        DE_OUT,
   output logic        HS_OUT,
   output logic        VS_OUT
);

   localparam logic [9:0] BX0_C  = 10'(BOARD_X0);
   localparam logic [9:0] BY0_C  = 10'(BOARD_Y0);
   localparam logic [9:0] NX0_C  = 10'(NEXT_X0);
   localparam logic [9:0] NY0_C  = 10'(NEXT_Y0);
   localparam logic [4:0] LAST_C = 5'(PITCH - 1);
   localparam logic [4:0] COLS_C = 5'(COLS);
   localparam logic [4:0] ROWS_C = 5'(ROWS);
   localparam logic [4:0] NLIM_C = 5'd4;

   // Once the index reaches its limit the sub-counter parks at LAST_C, so the
   // closing grid line is drawn once and nothing further on the line/frame.
   function automatic logic [9:0] step_pair(input logic [4:0] idx, input logic [4:0] sub,
                                            input logic [4:0] limit);
      logic [9:0] nxt;
      if (idx == limit) begin
         nxt = {idx, (sub == LAST_C) ? LAST_C : sub + 5'd1};
      end else if (sub == LAST_C) begin
         nxt = {idx + 5'd1, 5'd0};
      end else begin
         nxt = {idx, sub + 5'd1};
      end
      return nxt;
   endfunction

   function automatic logic in_span(input logic [4:0] idx, input logic [4:0] sub,
                                    input logic [4:0] limit, input logic vld);
      return vld & ((idx < limit) | ((idx == limit) & (sub == 5'd0)));
   endfunction

   logic [4:0] bx_idx_r, bx_sub_r, nx_idx_r, nx_sub_r;
   logic [4:0] by_idx_r, by_sub_r, ny_idx_r, ny_sub_r;
   logic       bx_vld_r, nx_vld_r, by_vld_r, ny_vld_r;

   logic       bx_load_s, nx_load_s, line_start_s;
   logic [4:0] bx_idx_s, bx_sub_s, nx_idx_s, nx_sub_s;
   logic       bx_vld_s, nx_vld_s;
   logic       b_in_s, n_in_s, b_grid_s, n_grid_s, b_int_s, n_int_s, n_bit_s;
   logic [7:0] row_x10_s, addr_s;
   logic [3:0] nidx_s;

   logic [7:0] cell_addr_r;
   logic       grid_r, b_int_r, n_on_r, de_r, hs_r, vs_r;
   logic [2:0] color_s, rgb_r;
   logic       de_out_r, hs_out_r, vs_out_r;

   // Counter values describing the pixel presented this cycle.
   assign bx_load_s    = (CounterX == BX0_C);
   assign nx_load_s    = (CounterX == NX0_C);
   assign line_start_s = (CounterX == 10'd0);
   assign bx_idx_s     = bx_load_s ? 5'd0 : bx_idx_r;
   assign bx_sub_s     = bx_load_s ? 5'd0 : bx_sub_r;
   assign bx_vld_s     = bx_load_s | bx_vld_r;
   assign nx_idx_s     = nx_load_s ? 5'd0 : nx_idx_r;
   assign nx_sub_s     = nx_load_s ? 5'd0 : nx_sub_r;
   assign nx_vld_s     = nx_load_s | nx_vld_r;

   assign b_in_s   = in_span(bx_idx_s, bx_sub_s, COLS_C, bx_vld_s)
                   & in_span(by_idx_r, by_sub_r, ROWS_C, by_vld_r);
   assign n_in_s   = in_span(nx_idx_s, nx_sub_s, NLIM_C, nx_vld_s)
                   & in_span(ny_idx_r, ny_sub_r, NLIM_C, ny_vld_r);
   assign b_grid_s = b_in_s & ((bx_sub_s == 5'd0) | (by_sub_r == 5'd0));
   assign n_grid_s = n_in_s & ((nx_sub_s == 5'd0) | (ny_sub_r == 5'd0));
   assign b_int_s  = b_in_s & ~b_grid_s;
   assign n_int_s  = n_in_s & ~n_grid_s;

   assign row_x10_s = {by_idx_r, 3'b000} + {2'b00, by_idx_r, 1'b0};
   assign addr_s    = row_x10_s + {3'b000, bx_idx_s};
   assign nidx_s    = {ny_idx_r[1:0], nx_idx_s[1:0]};
   assign n_bit_s   = NEXT_MASK[nidx_s];

   // Horizontal cell counters, advancing every pixel.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         bx_idx_r <= 5'd0;
         bx_sub_r <= 5'd0;
         bx_vld_r <= 1'b0;
         nx_idx_r <= 5'd0;
         nx_sub_r <= 5'd0;
         nx_vld_r <= 1'b0;
      end else begin
         {bx_idx_r, bx_sub_r} <= step_pair(bx_idx_s, bx_sub_s, COLS_C);
         bx_vld_r             <= bx_vld_s;
         {nx_idx_r, nx_sub_r} <= step_pair(nx_idx_s, nx_sub_s, NLIM_C);
         nx_vld_r             <= nx_vld_s;
      end
   end

   // Vertical cell counters, advancing once per line at CounterX==0.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         by_idx_r <= 5'd0;
         by_sub_r <= 5'd0;
         by_vld_r <= 1'b0;
         ny_idx_r <= 5'd0;
         ny_sub_r <= 5'd0;
         ny_vld_r <= 1'b0;
      end else if (line_start_s) begin
         if (CounterY == BY0_C) begin
            by_idx_r <= 5'd0;
            by_sub_r <= 5'd0;
            by_vld_r <= 1'b1;
         end else begin
            {by_idx_r, by_sub_r} <= step_pair(by_idx_r, by_sub_r, ROWS_C);
         end
         if (CounterY == NY0_C) begin
            ny_idx_r <= 5'd0;
            ny_sub_r <= 5'd0;
            ny_vld_r <= 1'b1;
         end else begin
            {ny_idx_r, ny_sub_r} <= step_pair(ny_idx_r, ny_sub_r, NLIM_C);
         end
      end
   end

   // Stage 0: cell address (held outside board interiors) and pixel classification.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cell_addr_r <= 8'd0;
         grid_r      <= 1'b0;
         b_int_r     <= 1'b0;
         n_on_r      <= 1'b0;
         de_r        <= 1'b0;
         hs_r        <= 1'b1;
         vs_r        <= 1'b1;
      end else begin
         if (b_int_s) begin
            cell_addr_r <= addr_s;
         end else begin
            cell_addr_r <= cell_addr_r;
         end
         grid_r  <= b_grid_s | n_grid_s;
         b_int_r <= b_int_s;
         n_on_r  <= n_int_s & n_bit_s;
         de_r    <= inDisplayArea;
         hs_r    <= HS_IN;
         vs_r    <= VS_IN;
      end
   end

   // Colour priority: grid, then board cell, then next-piece cell.
   always_comb begin
      color_s = 3'b000;
      if (grid_r) begin
         color_s = 3'b011;
      end else if (b_int_r) begin
         color_s = CELL_DATA;
      end else if (n_on_r) begin
         color_s = NEXT_COLOR;
      end else begin
         color_s = 3'b000;
      end
   end

   // Stage 1: registered pixel and aligned syncs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rgb_r    <= 3'b000;
         de_out_r <= 1'b0;
         hs_out_r <= 1'b1;
         vs_out_r <= 1'b1;
      end else begin
         rgb_r    <= color_s & {3{de_r}};
         de_out_r <= de_r;
         hs_out_r <= hs_r;
         vs_out_r <= vs_r;
      end
   end

   assign CELL_ADDR = cell_addr_r;
   assign R         = rgb_r[2];
   assign G         = rgb_r[1];
   assign B         = rgb_r[0];
   assign DE_OUT    = de_out_r;
   assign HS_OUT    = hs_out_r;
   assign VS_OUT    = vs_out_r;

endmodule
